// File: rtl/demux_1x4_4_reg_if.sv
// Handshake bundle for the 1-to-4 registered demultiplexer.
// master = producer/consumers (bench), slave = the demux itself.
interface demux_1x4_4_reg_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic             auto_mode;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [1:0]       auto_ptr;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output in_valid, in_data, sel, auto_mode, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, auto_ptr, xfer_count
  );

  modport slave (
    input  in_valid, in_data, sel, auto_mode, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, auto_ptr, xfer_count
  );
endinterface

// File: rtl/demux_1x4_4_reg.sv
// 1-to-4 demultiplexer with one registered slot per channel, manual or round-robin
// steering, and a saturating count of accepted input words.
module demux_1x4_4_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  demux_1x4_4_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [4];
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_tgt;
  logic             w_in_ready;
  logic             w_accept;

  assign w_tgt      = bus.auto_mode ? r_ptr : bus.sel;
  // A full target slot can still accept when it drains on the same edge.
  assign w_in_ready = rst_n & (~r_valid[w_tgt] | bus.out_ready[w_tgt]);
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '{default: '0};
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_tgt == 2'(k))) begin
          r_data[k]  <= bus.in_data;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] && bus.out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_accept && bus.auto_mode) begin
        r_ptr <= r_ptr + 2'd1;
      end
      if (w_accept && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_valid;
  assign bus.out_data0  = r_data[0];
  assign bus.out_data1  = r_data[1];
  assign bus.out_data2  = r_data[2];
  assign bus.out_data3  = r_data[3];
  assign bus.auto_ptr   = r_ptr;
  assign bus.xfer_count = r_cnt;

endmodule

// File: tb/tb_demux_1x4_4_reg.sv
// Bench for demux_1x4_4_reg: directed scenarios plus random traffic against a
// slot-level reference model; a second instance with a 2-bit counter checks saturation.
module tb_demux_1x4_4_reg;

  logic clk;
  logic rst_n;

  demux_1x4_4_reg_if #(.WIDTH(4), .CNT_W(8)) bus ();
  demux_1x4_4_reg_if #(.WIDTH(4), .CNT_W(2)) bus_s ();

  demux_1x4_4_reg #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  demux_1x4_4_reg #(.WIDTH(4), .CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.sel       = bus.sel;
  assign bus_s.auto_mode = bus.auto_mode;
  assign bus_s.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what each channel holds, the round-robin pointer, accept counts.
  logic [3:0] m_valid;
  logic [3:0] m_data [4];
  int         m_ptr;
  int         m_cnt;
  int         m_cnt_s;
  logic       m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    for (int k = 0; k < 4; k++) m_data[k] = '0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  task automatic check_state();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data0", 32'(bus.out_data0), 32'(m_data[0]));
    check("out_data1", 32'(bus.out_data1), 32'(m_data[1]));
    check("out_data2", 32'(bus.out_data2), 32'(m_data[2]));
    check("out_data3", 32'(bus.out_data3), 32'(m_data[3]));
    check("auto_ptr", 32'(bus.auto_ptr), 32'(m_ptr));
    check("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
    check("xfer_count_sat", 32'(bus_s.xfer_count), 32'(m_cnt_s));
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and state after it.
  task automatic step(input logic v, input logic [3:0] d, input logic [1:0] s,
                      input logic am, input logic [3:0] ordy);
    int   t;
    logic rdy;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.sel       = s;
    bus.auto_mode = am;
    bus.out_ready = ordy;
    #1;
    t   = am ? m_ptr : int'(s);
    rdy = !m_valid[t] || ordy[t];
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    check("in_ready_sat", 32'(bus_s.in_ready), 32'(rdy));
    @(posedge clk);
    m_acc = v && rdy;
    for (int k = 0; k < 4; k++) begin
      if (m_acc && t == k) begin
        m_data[k]  = d;
        m_valid[k] = 1'b1;
      end else if (m_valid[k] && ordy[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    if (m_acc) begin
      if (am) m_ptr = (m_ptr + 1) % 4;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
    #1;
    check_state();
  endtask

  initial begin
    logic [3:0] words [5];
    logic       v;
    logic [3:0] d;
    logic [1:0] s;
    words = '{4'h5, 4'hF, 4'h0, 4'hA, 4'h3};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h9;
    bus.sel       = 2'd1;
    bus.auto_mode = 1'b0;
    bus.out_ready = 4'hF;
    model_reset();
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_state();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Manual steer to channel 2 on the very first edge after reset release.
    step(1'b1, 4'hA, 2'd2, 1'b0, 4'h0);
    check("man_valid", 32'(bus.out_valid), 32'b0100);
    check("man_data2", 32'(bus.out_data2), 32'hA);
    check("man_count", 32'(bus.xfer_count), 32'd1);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'h0);

    // Backpressure on channel 1, then accept while it drains.
    step(1'b1, 4'h7, 2'd1, 1'b0, 4'h0);
    step(1'b1, 4'h5, 2'd1, 1'b0, 4'h0);
    check("bp_data1_held", 32'(bus.out_data1), 32'h7);
    step(1'b1, 4'h5, 2'd1, 1'b0, 4'b0010);
    check("bp_data1_new", 32'(bus.out_data1), 32'h5);
    check("bp_valid1", 32'(bus.out_valid[1]), 32'd1);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF);

    // Round-robin back-to-back with every consumer ready.
    check("auto_ptr_start", 32'(bus.auto_ptr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, words[i], 2'd3, 1'b1, 4'hF);
      check("auto_acc", 32'(m_acc), 32'd1);
      check("auto_ptr_seq", 32'(bus.auto_ptr), 32'((i + 1) % 4));
    end
    check("auto_ch0_last", 32'(bus.out_data0), 32'h3);
    check("auto_ch3", 32'(bus.out_data3), 32'hA);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'hF);

    // Fill 0 and 3, drain only 3.
    step(1'b1, 4'h6, 2'd0, 1'b0, 4'h0);
    step(1'b1, 4'h9, 2'd3, 1'b0, 4'h0);
    step(1'b0, 4'h0, 2'd0, 1'b0, 4'b1000);
    check("ind_valid", 32'(bus.out_valid), 32'b0001);
    check("ind_data0", 32'(bus.out_data0), 32'h6);
    check("ind_data3", 32'(bus.out_data3), 32'h9);
    check("sat_count", 32'(bus_s.xfer_count), 32'd3);

    // Fill everything, then reset between edges.
    step(1'b1, 4'h1, 2'd1, 1'b0, 4'h0);
    step(1'b1, 4'h2, 2'd2, 1'b0, 4'h0);
    step(1'b1, 4'h3, 2'd3, 1'b0, 4'h0);
    check("full_valid", 32'(bus.out_valid), 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'hC, 2'd3, 1'b0, 4'h0);
    check("post_rst_valid", 32'(bus.out_valid), 32'b1000);
    check("post_rst_data3", 32'(bus.out_data3), 32'hC);

    // Random traffic; a stalled producer keeps its word and manual select.
    v = 1'b0;
    d = '0;
    s = '0;
    m_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !m_acc)) begin
        v = ($urandom_range(0, 9) < 7);
        d = 4'($urandom);
        s = 2'($urandom);
      end
      step(v, d, s, 1'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1x4_4_reg.md
DEMUX_1X4_4_REG -- requirements
Module: demux_1x4_4_reg

Interface
REQ-001 Parameter WIDTH, default 4, data width of the input word and of each output channel.
REQ-002 Parameter CNT_W, default 8, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  producer has a word on in_data.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  WIDTH  word to steer.
REQ-008 sel  input  2  destination channel in manual mode.
REQ-009 auto_mode  input  1  1 = destination taken from internal pointer; 0 = from sel.
REQ-010 out_valid  output  4  bit k = channel k holds a word.
REQ-011 out_ready  input  4  bit k = consumer k takes the word this cycle.
REQ-012 out_data0..out_data3  output  WIDTH each  held word of channel 0..3.
REQ-013 auto_ptr  output  2  current auto-mode destination.
REQ-014 xfer_count  output  CNT_W  accepted input transfers, saturating.

Function
REQ-015 The target channel T SHALL be auto_ptr when auto_mode=1, else sel, evaluated combinationally each cycle.
REQ-016 Each channel SHALL hold one registered entry (data + valid bit); no other buffering.
REQ-017 in_ready SHALL equal rst_n AND (NOT out_valid[T] OR out_ready[T]), combinational.
REQ-018 Accept SHALL occur when in_valid AND in_ready; on that edge in_data loads into channel T and out_valid[T] becomes 1 (latency 1 cycle input to output).
REQ-019 Consume on channel k SHALL occur when out_valid[k] AND out_ready[k]; out_valid[k] clears on that edge unless an accept targets k in the same cycle.
REQ-020 Simultaneous accept and consume on the same channel SHALL load the new word with out_valid[k] staying 1 (full throughput, no bubble).
REQ-021 Accepts to one channel SHALL NOT alter data or valid of any other channel; channels drain independently.
REQ-022 out_dataK SHALL hold its last loaded value after consumption (not cleared).
REQ-023 in_valid with in_ready=0 SHALL change no state; producer must hold in_data/sel stable until accepted.
REQ-024 auto_ptr SHALL increment by 1 on each accept while auto_mode=1, wrapping 3->0; it SHALL NOT change in manual mode or on non-accepted cycles.
REQ-025 Toggling auto_mode SHALL NOT modify auto_ptr or any channel contents; the change takes effect on T in the same cycle.
REQ-026 xfer_count SHALL increment by 1 per accept in either mode and saturate at 2^CNT_W-1.
REQ-027 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force out_valid=0000, all out_dataK=0, auto_ptr=0, xfer_count=0, in_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard all held words; the accept in progress that cycle SHALL be lost.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-031 Manual: sel=2, in_data=4'hA, in_valid 1 cycle, out_ready=0 -> next cycle out_valid=0100, out_data2=A, xfer_count=1, others unchanged.
REQ-032 Backpressure: channel 1 full, out_ready[1]=0, sel=1, in_data=5 -> in_ready=0, out_data1 unchanged; assert out_ready[1] -> same-cycle accept, out_data1=5, out_valid[1] stays 1.
REQ-033 Auto: auto_mode=1, out_ready=1111, words 5,F,0,A,3 back-to-back -> channels 0,1,2,3,0 receive them, auto_ptr sequence 0,1,2,3,0,1, in_ready continuously 1.
REQ-034 Independence: fill channels 0 and 3, drain only 3 -> out_valid=0001, out_data0 retained, out_data3 retains last value.
REQ-035 Saturation: CNT_W=2, 5 accepts -> xfer_count 1,2,3,3,3.
REQ-036 Reset mid-stream: assert rst_n=0 between clock edges with out_valid=1111 -> all outputs zero before next edge; after release one accept with sel=3 -> out_valid=1000.
